ps2_mouse_ctrl: RTL and testbench

//  Sequences the PS/2 engine (TopmodulePS2) to bring up a PS/2 mouse and decode its stream packets.

---
 rtl/ps2_mouse_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_ps2_mouse_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_mouse_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ps2_mouse_ctrl : PS/2 mouse bring-up sequencer and 3-byte packet decoder    |
// | rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module ps2_mouse_ctrl #(
   parameter int clk_freq   = 50000000,
   parameter int TIMEOUT_MS = 20,
   parameter int RETRIES    = 3
) (
   input  logic       sys_clk,
   input  logic       sys_rst,
   input  logic       start,
   output logic [7:0] ps2_tx_data,
   output logic       ps2_tx_we,
   input  logic       ps2_tx_busy,
   input  logic       ps2_rx_avail,
   input  logic [7:0] ps2_rx_data,
   output logic       ready,
   output logic       error,
   output logic [3:0] state_o,
   output logic       pkt_valid,
   output logic [2:0] pkt_btn,
   output logic [8:0] pkt_dx,
   output logic [8:0] pkt_dy,
   output logic [1:0] pkt_ovf
);

   localparam int TO_CYC = clk_freq / 1000 * TIMEOUT_MS;
   localparam int TW     = $clog2(TO_CYC + 1);
   localparam int RW     = (RETRIES < 1) ? 1 : $clog2(RETRIES + 1);
   localparam logic [TW-1:0] TO_LIM    = TW'(TO_CYC);
   localparam logic [RW-1:0] RETRY_MAX = RW'(RETRIES);

   typedef enum logic [3:0] {
      S_IDLE         = 4'd0,
      S_SEND_RST     = 4'd1,
      S_WAIT_ACK_RST = 4'd2,
      S_WAIT_BAT     = 4'd3,
      S_WAIT_ID      = 4'd4,
      S_SEND_EN      = 4'd5,
      S_WAIT_ACK_EN  = 4'd6,
      S_STREAM       = 4'd7,
      S_ERROR        = 4'd8
   } state_t;

   state_t          state_q, state_d;
   logic [RW-1:0]   retry_q, retry_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic [1:0]      idx_q, idx_d;
   logic [7:0]      b0_q, b0_d;
   logic [7:0]      b1_q, b1_d;
   logic            rx_prev_q;
   logic [7:0]      tx_data_q, tx_data_d;
   logic            tx_we_q, tx_we_d;
   logic            pkt_valid_q, pkt_valid_d;
   logic [2:0]      pkt_btn_q, pkt_btn_d;
   logic [8:0]      pkt_dx_q, pkt_dx_d;
   logic [8:0]      pkt_dy_q, pkt_dy_d;
   logic [1:0]      pkt_ovf_q, pkt_ovf_d;

   logic            rx_ev;
   logic            timeout;
   logic            fail;
   logic [7:0]      exp_byte;
   state_t          succ_state;

   assign rx_ev   = ps2_rx_avail & ~rx_prev_q;
   assign timeout = (timer_q == TO_LIM);

   // Expected reply and follow-on state for each response-wait state.
   always_comb begin
      exp_byte   = 8'hFA;
      succ_state = S_STREAM;
      case (state_q)
         S_WAIT_ACK_RST: begin exp_byte = 8'hFA; succ_state = S_WAIT_BAT; end
         S_WAIT_BAT:     begin exp_byte = 8'hAA; succ_state = S_WAIT_ID;  end
         S_WAIT_ID:      begin exp_byte = 8'h00; succ_state = S_SEND_EN;  end
         default:        begin exp_byte = 8'hFA; succ_state = S_STREAM;   end
      endcase
   end

   always_comb begin
      state_d     = state_q;
      retry_d     = retry_q;
      idx_d       = idx_q;
      b0_d        = b0_q;
      b1_d        = b1_q;
      tx_data_d   = tx_data_q;
      tx_we_d     = 1'b0;
      pkt_valid_d = 1'b0;
      pkt_btn_d   = pkt_btn_q;
      pkt_dx_d    = pkt_dx_q;
      pkt_dy_d    = pkt_dy_q;
      pkt_ovf_d   = pkt_ovf_q;
      fail        = 1'b0;

      if (start) begin
         state_d = S_SEND_RST;
         retry_d = '0;
         idx_d   = '0;
      end else begin
         case (state_q)
            // The strobe is issued while still in the SEND state; the state
            // advances on the edge that ends the strobe.
            S_SEND_RST, S_SEND_EN: begin
               if (tx_we_q) begin
                  state_d = (state_q == S_SEND_RST) ? S_WAIT_ACK_RST : S_WAIT_ACK_EN;
               end else if (!ps2_tx_busy) begin
                  tx_we_d   = 1'b1;
                  tx_data_d = (state_q == S_SEND_RST) ? 8'hFF : 8'hF4;
               end
            end
            S_WAIT_ACK_RST, S_WAIT_BAT, S_WAIT_ID, S_WAIT_ACK_EN: begin
               if (rx_ev) begin
                  if (ps2_rx_data == exp_byte) begin
                     state_d = succ_state;
                     if (succ_state == S_SEND_EN || succ_state == S_STREAM) begin
                        retry_d = '0;
                     end
                  end else begin
                     fail = 1'b1;
                  end
               end else if (timeout) begin
                  fail = 1'b1;
               end
            end
            S_STREAM: begin
               if (rx_ev) begin
                  case (idx_q)
                     2'd0: begin
                        if (ps2_rx_data[3]) begin
                           b0_d  = ps2_rx_data;
                           idx_d = 2'd1;
                        end
                     end
                     2'd1: begin
                        b1_d  = ps2_rx_data;
                        idx_d = 2'd2;
                     end
                     default: begin
                        pkt_valid_d = 1'b1;
                        pkt_btn_d   = b0_q[2:0];
                        pkt_dx_d    = {b0_q[4], b1_q};
                        pkt_dy_d    = {b0_q[5], ps2_rx_data};
                        pkt_ovf_d   = {b0_q[7], b0_q[6]};
                        idx_d       = 2'd0;
                     end
                  endcase
               end else if (idx_q != 2'd0 && timeout) begin
                  idx_d = 2'd0;
               end
            end
            S_ERROR: begin
               state_d = S_ERROR;
            end
            default: begin
               state_d = S_SEND_RST;
            end
         endcase

         if (fail) begin
            if (retry_q != RETRY_MAX) begin
               retry_d = retry_q + 1'b1;
               state_d = (state_q == S_WAIT_ACK_EN) ? S_SEND_EN : S_SEND_RST;
            end else begin
               state_d = S_ERROR;
            end
         end
      end

      // Timer restarts on every state change; in STREAM it measures the gap
      // since the last byte and only matters mid-packet.
      if (start || state_d != state_q) begin
         timer_d = '0;
      end else if (state_q == S_STREAM && (rx_ev || idx_q == 2'd0)) begin
         timer_d = '0;
      end else if (timer_q != TO_LIM) begin
         timer_d = timer_q + 1'b1;
      end else begin
         timer_d = timer_q;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q     <= S_SEND_RST;
         retry_q     <= '0;
         timer_q     <= '0;
         idx_q       <= '0;
         b0_q        <= '0;
         b1_q        <= '0;
         rx_prev_q   <= 1'b0;
         tx_data_q   <= '0;
         tx_we_q     <= 1'b0;
         pkt_valid_q <= 1'b0;
         pkt_btn_q   <= '0;
         pkt_dx_q    <= '0;
         pkt_dy_q    <= '0;
         pkt_ovf_q   <= '0;
      end else begin
         state_q     <= state_d;
         retry_q     <= retry_d;
         timer_q     <= timer_d;
         idx_q       <= idx_d;
         b0_q        <= b0_d;
         b1_q        <= b1_d;
         rx_prev_q   <= ps2_rx_avail;
         tx_data_q   <= tx_data_d;
         tx_we_q     <= tx_we_d;
         pkt_valid_q <= pkt_valid_d;
         pkt_btn_q   <= pkt_btn_d;
         pkt_dx_q    <= pkt_dx_d;
         pkt_dy_q    <= pkt_dy_d;
         pkt_ovf_q   <= pkt_ovf_d;
      end
   end

   assign ps2_tx_data = tx_data_q;
   assign ps2_tx_we   = tx_we_q;
   assign ready       = (state_q == S_STREAM);
   assign error       = (state_q == S_ERROR);
   assign state_o     = state_q;
   assign pkt_valid   = pkt_valid_q;
   assign pkt_btn     = pkt_btn_q;
   assign pkt_dx      = pkt_dx_q;
   assign pkt_dy      = pkt_dy_q;
   assign pkt_ovf     = pkt_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_mouse_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ps2_mouse_ctrl : self-checking bench for the PS/2 mouse sequencer        |
// | rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_ps2_mouse_ctrl;

   localparam int TO_CYC = 200;

   typedef struct packed {
      logic [2:0] btn;
      logic [8:0] dx;
      logic [8:0] dy;
      logic [1:0] ovf;
   } pkt_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       busy_model = 1'b0;
   logic       busy_force = 1'b0;
   logic       busy;
   logic       rx_avail = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic [7:0] ps2_tx_data;
   logic       ps2_tx_we;
   logic       ps2_ready;
   logic       ps2_error;
   logic [3:0] state_o;
   logic       pkt_valid;
   logic [2:0] pkt_btn;
   logic [8:0] pkt_dx;
   logic [8:0] pkt_dy;
   logic [1:0] pkt_ovf;

   int   n_cmp = 0;
   int   n_bad = 0;
   int   pkt_seen = 0;
   int   mode = 0;           // 0 don't care, 1 streaming, 2 error, 3 initialising
   logic busy_prev = 1'b0;

   logic [7:0] exp_tx[$];
   pkt_t       exp_pkt[$];
   logic [7:0] sbuf[$];

   assign busy = busy_model | busy_force;

   always #5 clk = ~clk;

   ps2_mouse_ctrl #(
      .clk_freq   (100000),
      .TIMEOUT_MS (2),
      .RETRIES    (3)
   ) dut (
      .sys_clk      (clk),
      .sys_rst      (rst),
      .start        (start),
      .ps2_tx_data  (ps2_tx_data),
      .ps2_tx_we    (ps2_tx_we),
      .ps2_tx_busy  (busy),
      .ps2_rx_avail (rx_avail),
      .ps2_rx_data  (rx_data),
      .ready        (ps2_ready),
      .error        (ps2_error),
      .state_o      (state_o),
      .pkt_valid    (pkt_valid),
      .pkt_btn      (pkt_btn),
      .pkt_dx       (pkt_dx),
      .pkt_dy       (pkt_dy),
      .pkt_ovf      (pkt_ovf)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   // Packet assembly model: sync byte needs bit3, three bytes make a packet.
   function automatic void model_byte(input logic [7:0] b);
      pkt_t p;
      if (sbuf.size() == 0 && !b[3]) return;
      sbuf.push_back(b);
      if (sbuf.size() == 3) begin
         p.btn = sbuf[0][2:0];
         p.dx  = {sbuf[0][4], sbuf[1]};
         p.dy  = {sbuf[0][5], sbuf[2]};
         p.ovf = {sbuf[0][7], sbuf[0][6]};
         exp_pkt.push_back(p);
         sbuf.delete();
      end
   endfunction

   // Engine model: busy for 30 cycles after each write strobe.
   initial forever begin
      @(posedge clk); #2;
      if (ps2_tx_we) begin
         busy_model = 1'b1;
         repeat (30) @(posedge clk);
         #2 busy_model = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (ps2_tx_we) begin
            check("tx_we_while_busy", {31'd0, busy_prev}, 32'd0);
            if (exp_tx.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL unexpected_tx: got write of %0h, required no write", ps2_tx_data);
            end else begin
               check("tx_byte", {24'd0, ps2_tx_data}, {24'd0, exp_tx.pop_front()});
            end
         end
         if (pkt_valid) begin
            pkt_seen++;
            if (exp_pkt.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL unexpected_pkt: got pkt dx=%0h dy=%0h, required none", pkt_dx, pkt_dy);
            end else begin
               pkt_t p;
               p = exp_pkt.pop_front();
               check("pkt_btn", {29'd0, pkt_btn}, {29'd0, p.btn});
               check("pkt_dx",  {23'd0, pkt_dx},  {23'd0, p.dx});
               check("pkt_dy",  {23'd0, pkt_dy},  {23'd0, p.dy});
               check("pkt_ovf", {30'd0, pkt_ovf}, {30'd0, p.ovf});
            end
         end
         case (mode)
            1: begin
               check("ready_in_stream", {31'd0, ps2_ready}, 32'd1);
               check("error_in_stream", {31'd0, ps2_error}, 32'd0);
               check("state_in_stream", {28'd0, state_o}, 32'd7);
            end
            2: begin
               check("error_in_error", {31'd0, ps2_error}, 32'd1);
               check("ready_in_error", {31'd0, ps2_ready}, 32'd0);
               check("state_in_error", {28'd0, state_o}, 32'd8);
            end
            3: begin
               check("ready_in_init", {31'd0, ps2_ready}, 32'd0);
               check("error_in_init", {31'd0, ps2_error}, 32'd0);
            end
            default: ;
         endcase
      end
      busy_prev = busy;
   end

   task automatic send_byte(input logic [7:0] b, input bit stream);
      @(posedge clk); #1;
      rx_data  = b;
      rx_avail = 1'b1;
      if (stream) model_byte(b);
      repeat (2) @(posedge clk);
      #1 rx_avail = 1'b0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic wait_tx(input string name, input int max_cyc, output int cyc);
      cyc = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (ps2_tx_we) break;
         if (cyc >= max_cyc) begin
            n_cmp++; n_bad++;
            $display("FAIL %s: got no tx_we in %0d cycles, required a write", name, max_cyc);
            break;
         end
      end
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      sbuf.delete();
   endtask

   // Continues bring-up from WAIT_ACK_RST through to STREAM.
   task automatic finish_init();
      int c;
      send_byte(8'hFA, 0);
      send_byte(8'hAA, 0);
      exp_tx.push_back(8'hF4);
      send_byte(8'h00, 0);
      wait_tx("tx_enable", 80, c);
      check("tx_enable_byte",  {24'd0, ps2_tx_data}, 32'hF4);
      check("tx_enable_state", {28'd0, state_o}, 32'd5);
      mode = 0;
      send_byte(8'hFA, 0);
      mode = 1;
      check("ready_after_init", {31'd0, ps2_ready}, 32'd1);
      check("state_after_init", {28'd0, state_o}, 32'd7);
   endtask

   initial begin
      int c, k, p0;

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_tx_we",     {31'd0, ps2_tx_we}, 32'd0);
      check("rst_tx_data",   {24'd0, ps2_tx_data}, 32'd0);
      check("rst_ready",     {31'd0, ps2_ready}, 32'd0);
      check("rst_error",     {31'd0, ps2_error}, 32'd0);
      check("rst_state",     {28'd0, state_o}, 32'd1);
      check("rst_pkt_valid", {31'd0, pkt_valid}, 32'd0);
      check("rst_pkt_dx",    {23'd0, pkt_dx}, 32'd0);
      check("rst_pkt_dy",    {23'd0, pkt_dy}, 32'd0);
      check("rst_pkt_btn",   {29'd0, pkt_btn}, 32'd0);
      check("rst_pkt_ovf",   {30'd0, pkt_ovf}, 32'd0);
      exp_tx.push_back(8'hFF);
      @(posedge clk); #1 rst = 1'b0;
      mode = 3;

      // 1: bring-up
      wait_tx("tx_reset", 20, c);
      check("first_tx_latency_ok", {31'd0, (c >= 2 && c <= 3)}, 32'd1);
      check("tx_reset_byte",  {24'd0, ps2_tx_data}, 32'hFF);
      check("tx_reset_state", {28'd0, state_o}, 32'd1);
      finish_init();

      // 2: packets
      p0 = pkt_seen;
      send_byte(8'h09, 1); send_byte(8'h05, 1); send_byte(8'hFB, 1);
      check("pktA_count", pkt_seen - p0, 32'd1);
      check("pktA_btn", {29'd0, pkt_btn}, 32'h1);
      check("pktA_dx",  {23'd0, pkt_dx}, 32'h005);
      check("pktA_dy",  {23'd0, pkt_dy}, 32'h0FB);
      send_byte(8'h29, 1); send_byte(8'hFF, 1); send_byte(8'h01, 1);
      check("pktB_dx",  {23'd0, pkt_dx}, 32'h0FF);
      check("pktB_dy",  {23'd0, pkt_dy}, 32'h101);
      send_byte(8'hDF, 1); send_byte(8'h80, 1); send_byte(8'h7F, 1);
      check("pktC_btn", {29'd0, pkt_btn}, 32'h7);
      check("pktC_dx",  {23'd0, pkt_dx}, 32'h180);
      check("pktC_dy",  {23'd0, pkt_dy}, 32'h07F);
      check("pktC_ovf", {30'd0, pkt_ovf}, 32'h3);

      // 3: resync on missing bit3
      p0 = pkt_seen;
      send_byte(8'h05, 1);
      send_byte(8'h08, 1); send_byte(8'h01, 1); send_byte(8'h02, 1);
      check("resync_count", pkt_seen - p0, 32'd1);
      check("resync_btn", {29'd0, pkt_btn}, 32'h0);
      check("resync_dx",  {23'd0, pkt_dx}, 32'h001);
      check("resync_dy",  {23'd0, pkt_dy}, 32'h002);

      // 5: inter-byte timeout drops partial packet
      p0 = pkt_seen;
      send_byte(8'h08, 1); send_byte(8'h03, 1);
      repeat (TO_CYC + 10) @(posedge clk);
      #1 sbuf.delete();
      send_byte(8'h08, 1); send_byte(8'h01, 1); send_byte(8'h02, 1);
      check("partial_to_count", pkt_seen - p0, 32'd1);
      check("partial_to_dx", {23'd0, pkt_dx}, 32'h001);

      // 6a: restart mid-packet while engine busy
      p0 = pkt_seen;
      send_byte(8'h08, 1);
      exp_tx.push_back(8'hFF);
      busy_force = 1'b1;
      pulse_start();
      mode = 3;
      @(negedge clk);
      check("restart_ready", {31'd0, ps2_ready}, 32'd0);
      check("restart_state", {28'd0, state_o}, 32'd1);
      repeat (10) @(posedge clk);
      #1 busy_force = 1'b0;
      wait_tx("restart_tx", 40, c);
      check("restart_tx_byte", {24'd0, ps2_tx_data}, 32'hFF);
      check("restart_no_pkt", pkt_seen - p0, 32'd0);

      // 4: retries then ERROR
      exp_tx.push_back(8'hFF);
      send_byte(8'hFE, 0);
      wait_tx("resend_fe", 80, c);
      check("resend_fe_byte", {24'd0, ps2_tx_data}, 32'hFF);
      for (int i = 0; i < 2; i++) begin
         exp_tx.push_back(8'hFF);
         wait_tx("resend_timeout", 300, c);
         check("resend_gap_ok", {31'd0, (c >= TO_CYC && c <= TO_CYC + 15)}, 32'd1);
      end
      mode = 0;
      k = 0;
      while (!ps2_error && k < 300) begin
         @(negedge clk);
         k++;
      end
      check("error_reached", {31'd0, ps2_error}, 32'd1);
      check("error_state",   {28'd0, state_o}, 32'd8);
      check("error_after_to_ok", {31'd0, (k >= TO_CYC && k <= TO_CYC + 15)}, 32'd1);
      mode = 2;
      send_byte(8'hFA, 0);
      repeat (TO_CYC + 50) @(posedge clk);
      #1;

      // 6b: restart from ERROR and bring up again
      exp_tx.push_back(8'hFF);
      pulse_start();
      mode = 3;
      wait_tx("error_restart_tx", 40, c);
      check("error_restart_byte", {24'd0, ps2_tx_data}, 32'hFF);
      finish_init();
      p0 = pkt_seen;
      send_byte(8'h18, 1); send_byte(8'h10, 1); send_byte(8'h20, 1);
      check("final_count", pkt_seen - p0, 32'd1);
      check("final_dx", {23'd0, pkt_dx}, 32'h110);

      repeat (5) @(posedge clk);
      #1;
      check("tx_queue_drained",  exp_tx.size(), 32'd0);
      check("pkt_queue_drained", exp_pkt.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no end of test, required completion within time limit");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
